// File: rtl/aes_pkg.sv
// aes_pkg: shared AES stream datapath constants, block type, serializer state and sizing helpers.
package aes_pkg;

    localparam int BLOCK_W     = 128;
    localparam int BLOCK_BYTES = BLOCK_W / 8;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic {IDLE, SEND} ser_state_e;

    function automatic int nbytes_width();
        return $clog2(BLOCK_BYTES + 1);
    endfunction

    function automatic int beats_for_width(int w);
        return BLOCK_W / w;
    endfunction

    function automatic int cnt_width(int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int NBYTES_W = nbytes_width();

endpackage

// File: rtl/aes_axis_keep_gen.sv
// aes_axis_keep_gen: byte-enable and final-beat decode for a partially filled last block.
module aes_axis_keep_gen
    import aes_pkg::*;
#(
    parameter int W     = 32,
    parameter int BEATS = beats_for_width(W),
    parameter int CW    = cnt_width(BEATS)
) (
    input  logic                last_i,
    input  logic [NBYTES_W-1:0] nbytes_i,
    input  logic [CW-1:0]       cnt_i,
    output logic [W/8-1:0]      keep_o,
    output logic                final_beat_o
);

    localparam int KB = W / 8;

    int   nb;
    int   last_idx;
    int   rem;
    logic at_last;

    // Out-of-range byte counts are treated as a full block.
    always_comb begin
        nb           = (nbytes_i == '0 || int'(nbytes_i) > BLOCK_BYTES) ? BLOCK_BYTES : int'(nbytes_i);
        last_idx     = (nb + KB - 1) / KB - 1;
        rem          = nb % KB;
        at_last      = last_i && int'(cnt_i) == last_idx;
        final_beat_o = last_i ? at_last : int'(cnt_i) == BEATS - 1;
        for (int i = 0; i < KB; i++) keep_o[i] = !at_last || rem == 0 || i < rem;
    end

endmodule

// File: rtl/aes_axis_block_serializer.sv
// aes_axis_block_serializer: 128-bit cipher blocks -> AXI4-Stream master beats, zero-bubble.
// Define AES_AXIS_TKEEP_EN to add s_blk_nbytes / m_axis_tkeep for short last blocks.
module aes_axis_block_serializer
    import aes_pkg::*;
#(
    parameter int BLOCK_WIDTH        = 128,
    parameter int M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BLOCK_WIDTH-1:0]        s_blk_data,
    input  logic                          s_blk_last,
`ifdef AES_AXIS_TKEEP_EN
    input  logic [NBYTES_W-1:0]           s_blk_nbytes,
    output logic [M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
`endif
    input  logic                          s_blk_valid,
    output logic                          s_blk_ready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    localparam int W     = M_AXIS_TDATA_WIDTH;
    localparam int BEATS = beats_for_width(W);
    localparam int CW    = cnt_width(BEATS);

    ser_state_e             state_q;
    logic [BLOCK_WIDTH-1:0] blk_q;
    logic                   last_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   final_beat;
    logic                   accept;

`ifdef AES_AXIS_TKEEP_EN
    logic [NBYTES_W-1:0] nbytes_q;
    logic [W/8-1:0]      keep;

    aes_axis_keep_gen #(.W(W)) u_keep_gen (
        .last_i       (last_q),
        .nbytes_i     (nbytes_q),
        .cnt_i        (cnt_q),
        .keep_o       (keep),
        .final_beat_o (final_beat)
    );

    assign m_axis_tkeep = (state_q == SEND) ? keep : '0;
`else
    assign final_beat = cnt_q == CW'(BEATS - 1);
`endif

    assign cnt_d         = cnt_q + CW'(1);
    assign s_blk_ready   = (state_q == IDLE) || (state_q == SEND && final_beat && m_axis_tready);
    assign accept        = s_blk_valid && s_blk_ready;
    assign m_axis_tvalid = state_q == SEND;
    assign m_axis_tlast  = state_q == SEND && last_q && final_beat;

    if (BEATS == 1) begin : g_slice
        assign m_axis_tdata = blk_q[W-1:0];
    end else begin : g_mux
        assign m_axis_tdata = blk_q[int'(cnt_q)*W +: W];
    end

    // A final-beat handshake and a new block acceptance share the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            blk_q    <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef AES_AXIS_TKEEP_EN
            nbytes_q <= '0;
`endif
        end else if (accept) begin
            state_q  <= SEND;
            blk_q    <= s_blk_data;
            last_q   <= s_blk_last;
            cnt_q    <= '0;
`ifdef AES_AXIS_TKEEP_EN
            nbytes_q <= s_blk_nbytes;
`endif
        end else if (state_q == SEND && m_axis_tready) begin
            if (final_beat) state_q <= IDLE;
            else cnt_q <= cnt_d;
        end
    end

endmodule
